// File: rtl/xgmm_writer.sv
// Drains XGRI pattern/attribute FIFOs into VRAM write ports; XGMM_VBLANK_ONLY_EN restricts new service to vblank.
// Latency: 9 cycles per 64-bit pattern write, 2 per attribute write; a write holds req until ack and blocks all pops.
module xgmm_writer #(
  parameter int PAT_WORDS = 4,
  parameter int PAT_AW    = 12,
  parameter int ATTR_AW   = 15
) (
  input  logic                    clk_sys,
  input  logic                    rst_n,
  input  logic                    p_empty,
  input  logic [15:0]             p_data,
  input  logic [PAT_AW-1:0]       par,
  output logic                    p_pop,
  input  logic                    a_empty,
  input  logic [15:0]             a_data,
  input  logic [ATTR_AW-1:0]      aar,
  output logic                    a_pop,
  input  logic                    vblank,
  output logic                    pat_wr_req,
  output logic [PAT_AW-1:0]       pat_wr_addr,
  output logic [16*PAT_WORDS-1:0] pat_wr_data,
  input  logic                    pat_wr_ack,
  output logic                    attr_wr_req,
  output logic [ATTR_AW-1:0]      attr_wr_addr,
  output logic [15:0]             attr_wr_data,
  input  logic                    attr_wr_ack,
  output logic                    busy
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    P_POP   = 3'd1,
    P_GAP   = 3'd2,
    P_WRITE = 3'd3,
    A_POP   = 3'd4,
    A_WRITE = 3'd5
  } state_t;

  localparam logic [1:0] CNT_LAST = 2'(PAT_WORDS - 1);

  state_t     state;
  logic [1:0] cnt;
  logic       rr_attr;
  logic       start_ok;

`ifdef XGMM_VBLANK_ONLY_EN
  assign start_ok = vblank;
`else
  logic unused_vblank;
  assign unused_vblank = vblank;
  assign start_ok      = 1'b1;
`endif

  // Pops are decoded from state so the FIFO head advances on the same edge that captures it.
  assign p_pop = (state == P_POP) && !p_empty;
  assign a_pop = (state == A_POP) && !a_empty;
  assign busy  = (state != IDLE);

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      cnt          <= 2'd0;
      rr_attr      <= 1'b0;
      pat_wr_req   <= 1'b0;
      pat_wr_addr  <= '0;
      pat_wr_data  <= '0;
      attr_wr_req  <= 1'b0;
      attr_wr_addr <= '0;
      attr_wr_data <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start_ok) begin
            if (!p_empty && (a_empty || !rr_attr)) begin
              state <= P_POP;
            end else if (!a_empty) begin
              state <= A_POP;
            end
          end
        end
        P_POP: begin
          if (!p_empty) begin
            pat_wr_data[{cnt, 4'b0000} +: 16] <= p_data;
            // par only moves after the last pop of a burst, so word0 time holds the burst address.
            if (cnt == 2'd0) begin
              pat_wr_addr <= par;
            end
            state <= P_GAP;
          end
        end
        P_GAP: begin
          if (cnt == CNT_LAST) begin
            cnt        <= 2'd0;
            pat_wr_req <= 1'b1;
            state      <= P_WRITE;
          end else begin
            cnt   <= cnt + 2'd1;
            state <= P_POP;
          end
        end
        P_WRITE: begin
          if (pat_wr_ack) begin
            pat_wr_req <= 1'b0;
            rr_attr    <= 1'b1;
            state      <= IDLE;
          end
        end
        A_POP: begin
          if (!a_empty) begin
            attr_wr_data <= a_data;
            attr_wr_addr <= aar;
            attr_wr_req  <= 1'b1;
            state        <= A_WRITE;
          end else begin
            state <= IDLE;
          end
        end
        A_WRITE: begin
          if (attr_wr_ack) begin
            attr_wr_req <= 1'b0;
            rr_attr     <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
